// File: rtl/vga_textctl.sv
// vga_textctl: write controller for the 80x30 character/attribute RAMs.
// Owns the cursor and sequences put-char, set-cursor, clear and scroll-up traffic.
module vga_textctl (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [6:0]  cmd_char,
    input  logic [7:0]  cmd_attr,
    input  logic [11:0] cmd_pos,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [6:0]  wr_char,
    output logic [7:0]  wr_attr,
    output logic [11:0] rd_addr,
    input  logic [6:0]  rd_char,
    input  logic [7:0]  rd_attr,
    output logic [11:0] cursor_pos,
    output logic        busy
);
    localparam logic [11:0] COLS = 12'd80, LAST = 12'd2399, LAST_ROW = 12'd2320, COPY_END = 12'd2319;
    localparam logic [1:0] OP_PUTC = 2'd0, OP_SETPOS = 2'd1, OP_CLEAR = 2'd2, OP_SCROLL = 2'd3;
    localparam logic [6:0] CH_LF = 7'h0A, CH_CR = 7'h0D;

    typedef enum logic [2:0] {IDLE, PUTC, SCR_PRIME, SCR_COPY, FILL} state_t;

    state_t      state_q, state_d;
    logic [11:0] cursor_q, cursor_d, wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, pos_q, pos_d, col;
    logic [6:0]  wr_char_q, wr_char_d, char_q, char_d;
    logic [7:0]  wr_attr_q, wr_attr_d, fill_q, fill_d;
    logic [1:0]  op_q, op_d;
    logic        wr_en_q, wr_en_d, auto_q, auto_d, clr_q, clr_d;

    assign col = cursor_q % COLS;

    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_char_d = wr_char_q;
        wr_attr_d = wr_attr_q;
        rd_addr_d = rd_addr_q;
        pos_d     = pos_q;
        char_d    = char_q;
        fill_d    = fill_q;
        op_d      = op_q;
        auto_d    = auto_q;
        clr_d     = clr_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                op_d   = cmd_op;
                char_d = cmd_char;
                pos_d  = cmd_pos;
                fill_d = (cmd_op == OP_PUTC) ? 8'h00 : cmd_attr;
                auto_d = 1'b0;
                clr_d  = 1'b0;
                if (cmd_op == OP_SCROLL || (cmd_op == OP_PUTC && cmd_char == CH_LF && cursor_q >= LAST_ROW)) begin
                    state_d   = SCR_PRIME;
                    rd_addr_d = COLS;
                    auto_d    = (cmd_op == OP_PUTC);
                end else if (cmd_op == OP_CLEAR) begin
                    state_d   = FILL;
                    wr_en_d   = 1'b1;
                    wr_addr_d = 12'd0;
                    wr_char_d = 7'd0;
                    wr_attr_d = cmd_attr;
                    clr_d     = 1'b1;
                end else begin
                    state_d = PUTC;
                    if (cmd_op == OP_PUTC && cmd_char != CH_LF && cmd_char != CH_CR) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cursor_q;
                        wr_char_d = cmd_char;
                        wr_attr_d = cmd_attr;
                        auto_d    = (cursor_q == LAST);
                    end
                end
            end
            PUTC: if (auto_q) begin
                state_d   = SCR_PRIME;
                rd_addr_d = COLS;
            end else begin
                state_d  = IDLE;
                cursor_d = (op_q == OP_SETPOS) ? ((pos_q <= LAST) ? pos_q : cursor_q) :
                           (char_q == CH_CR)   ? cursor_q - col :
                           (char_q == CH_LF)   ? cursor_q - col + COLS : cursor_q + 12'd1;
            end
            SCR_PRIME: begin
                state_d   = SCR_COPY;
                rd_addr_d = rd_addr_q + 12'd1;
                wr_en_d   = 1'b1;
                wr_addr_d = 12'd0;
            end
            SCR_COPY: begin
                wr_en_d = 1'b1;
                if (wr_addr_q == COPY_END) begin
                    state_d   = FILL;
                    wr_addr_d = LAST_ROW;
                    wr_char_d = 7'd0;
                    wr_attr_d = fill_q;
                end else begin
                    wr_addr_d = wr_addr_q + 12'd1;
                    rd_addr_d = (rd_addr_q == LAST) ? rd_addr_q : rd_addr_q + 12'd1;
                end
            end
            FILL: if (wr_addr_q == LAST) begin
                state_d  = IDLE;
                cursor_d = clr_q ? 12'd0 : auto_q ? LAST_ROW : (cursor_q >= COLS) ? cursor_q - COLS : cursor_q;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = wr_addr_q + 12'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cursor_q  <= 12'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 12'd0;
            wr_char_q <= 7'd0;
            wr_attr_q <= 8'd0;
            rd_addr_q <= 12'd0;
            pos_q     <= 12'd0;
            char_q    <= 7'd0;
            fill_q    <= 8'd0;
            op_q      <= 2'd0;
            auto_q    <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_char_q <= wr_char_d;
            wr_attr_q <= wr_attr_d;
            rd_addr_q <= rd_addr_d;
            pos_q     <= pos_d;
            char_q    <= char_d;
            fill_q    <= fill_d;
            op_q      <= op_d;
            auto_q    <= auto_d;
            clr_q     <= clr_d;
        end
    end

    // Copy data bypasses the output register so each copy cycle writes the cell just read.
    assign wr_char    = (state_q == SCR_COPY) ? rd_char : wr_char_q;
    assign wr_attr    = (state_q == SCR_COPY) ? rd_attr : wr_attr_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign rd_addr    = rd_addr_q;
    assign cursor_pos = cursor_q;
    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_vga_textctl.sv
// tb_vga_textctl: directed bench for vga_textctl with a one-cycle-latency RAM model.
module tb_vga_textctl;
    logic        clk_in = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, pre = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [6:0]  cmd_char = '0;
    logic [7:0]  cmd_attr = '0;
    logic [11:0] cmd_pos = '0;
    logic        cmd_ready, wr_en, busy;
    logic [11:0] wr_addr, rd_addr, cursor_pos;
    logic [6:0]  wr_char, rd_char;
    logic [7:0]  wr_attr, rd_attr;

    logic [6:0]  ram_c[2400], snap_c[2400];
    logic [7:0]  ram_a[2400], snap_a[2400];
    int          wr_cnt = 0, seq_bad = 0, idle_wr = 0, oob = 0;
    logic        prev_en = 1'b0;
    logic [11:0] prev_addr = '0, last_addr = '0;
    int          n_chk = 0, n_pass = 0;

    vga_textctl dut (
        .clk_in(clk_in), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_char(cmd_char), .cmd_attr(cmd_attr), .cmd_pos(cmd_pos),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char), .wr_attr(wr_attr),
        .rd_addr(rd_addr), .rd_char(rd_char), .rd_attr(rd_attr),
        .cursor_pos(cursor_pos), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: write port plus registered read, and write-port bookkeeping.
    always @(posedge clk_in) begin
        if (pre) begin
            for (int i = 0; i < 2400; i++) begin
                ram_c[i] = 7'(i);
                ram_a[i] = 8'(i) ^ 8'h55;
            end
        end else if (wr_en) begin
            if (wr_addr < 12'd2400) begin
                ram_c[wr_addr] = wr_char;
                ram_a[wr_addr] = wr_attr;
            end else oob++;
            wr_cnt++;
            if (prev_en && wr_addr != prev_addr + 12'd1) seq_bad++;
            if (cmd_ready) idle_wr++;
            last_addr = wr_addr;
        end
        prev_en   = wr_en;
        prev_addr = wr_addr;
        rd_char <= ram_c[(rd_addr < 12'd2400) ? rd_addr : 12'd0];
        rd_attr <= ram_a[(rd_addr < 12'd2400) ? rd_addr : 12'd0];
    end

    task automatic issue(input logic [1:0] op, input logic [6:0] ch, input logic [7:0] at, input logic [11:0] pos);
        int t = 0;
        cmd_op = op; cmd_char = ch; cmd_attr = at; cmd_pos = pos; cmd_valid = 1'b1;
        while (!cmd_ready && t < 6000) begin @(negedge clk_in); t++; end
        if (!cmd_ready) begin n_chk++; $display("FAIL issue_timeout cmd_ready stuck low"); end
        @(negedge clk_in);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!cmd_ready && n < 6000) begin n++; @(negedge clk_in); end
        if (!cmd_ready) begin n_chk++; $display("FAIL idle_timeout busy after %0d cycles", n); end
    endtask

    function automatic void snap();
        for (int i = 0; i < 2400; i++) begin snap_c[i] = ram_c[i]; snap_a[i] = ram_a[i]; end
    endfunction

    function automatic int scroll_bad(input logic [7:0] fill);
        int b = 0;
        for (int d = 0; d < 2400; d++)
            if (d < 2320 ? (ram_c[d] !== snap_c[d+80] || ram_a[d] !== snap_a[d+80]) : (ram_c[d] !== 7'd0 || ram_a[d] !== fill)) b++;
        return b;
    endfunction

    task automatic test_reset();
        pre = 1'b1;
        @(negedge clk_in); @(negedge clk_in);
        pre = 1'b0;
        n_chk++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", cmd_ready); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        n_chk++; if (wr_en !== 1'b0) $display("FAIL rst_wr_en got %b want 0", wr_en); else n_pass++;
        n_chk++; if (wr_addr !== 12'd0) $display("FAIL rst_wr_addr got %0d want 0", wr_addr); else n_pass++;
        n_chk++; if (wr_char !== 7'd0) $display("FAIL rst_wr_char got %h want 0", wr_char); else n_pass++;
        n_chk++; if (wr_attr !== 8'd0) $display("FAIL rst_wr_attr got %h want 0", wr_attr); else n_pass++;
        n_chk++; if (rd_addr !== 12'd0) $display("FAIL rst_rd_addr got %0d want 0", rd_addr); else n_pass++;
        n_chk++; if (cursor_pos !== 12'd0) $display("FAIL rst_cursor got %0d want 0", cursor_pos); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_putc();
        int n, w0;
        w0 = wr_cnt;
        issue(2'd0, 7'h41, 8'h07, 12'd0);
        n_chk++; if (wr_en !== 1'b1 || wr_addr !== 12'd0) $display("FAIL putc_write got en=%b addr=%0d want en=1 addr=0", wr_en, wr_addr); else n_pass++;
        n_chk++; if (wr_char !== 7'h41 || wr_attr !== 8'h07) $display("FAIL putc_data got %h/%h want 41/07", wr_char, wr_attr); else n_pass++;
        n_chk++; if (cmd_ready !== 1'b0 || busy !== 1'b1) $display("FAIL putc_busy got ready=%b busy=%b want 0/1", cmd_ready, busy); else n_pass++;
        wait_idle(n);
        n_chk++; if (n !== 1) $display("FAIL putc_cycles got %0d want 1", n); else n_pass++;
        n_chk++; if (cursor_pos !== 12'd1) $display("FAIL putc_cursor got %0d want 1", cursor_pos); else n_pass++;
        n_chk++; if (wr_cnt - w0 !== 1 || ram_c[0] !== 7'h41) $display("FAIL putc_count got %0d writes ram0=%h want 1 and 41", wr_cnt - w0, ram_c[0]); else n_pass++;
    endtask

    task automatic test_setpos();
        int n, w0;
        issue(2'd1, 7'd0, 8'd0, 12'd79); wait_idle(n);
        n_chk++; if (cursor_pos !== 12'd79) $display("FAIL setpos_79 got %0d want 79", cursor_pos); else n_pass++;
        issue(2'd0, 7'h42, 8'h07, 12'd0);
        n_chk++; if (wr_addr !== 12'd79 || wr_char !== 7'h42) $display("FAIL putc79_write got addr=%0d ch=%h want 79/42", wr_addr, wr_char); else n_pass++;
        wait_idle(n);
        n_chk++; if (cursor_pos !== 12'd80) $display("FAIL putc79_cursor got %0d want 80", cursor_pos); else n_pass++;
        w0 = wr_cnt;
        issue(2'd1, 7'd0, 8'd0, 12'd2400); wait_idle(n);
        n_chk++; if (cursor_pos !== 12'd80) $display("FAIL setpos_oob got %0d want 80", cursor_pos); else n_pass++;
        issue(2'd0, 7'h0D, 8'd0, 12'd0); wait_idle(n);
        n_chk++; if (cursor_pos !== 12'd80) $display("FAIL cr_col0 got %0d want 80", cursor_pos); else n_pass++;
        issue(2'd0, 7'h0A, 8'd0, 12'd0); wait_idle(n);
        n_chk++; if (cursor_pos !== 12'd160 || n !== 1) $display("FAIL lf got cursor=%0d cycles=%0d want 160/1", cursor_pos, n); else n_pass++;
        issue(2'd1, 7'd0, 8'd0, 12'd85); wait_idle(n);
        issue(2'd0, 7'h0D, 8'd0, 12'd0); wait_idle(n);
        n_chk++; if (cursor_pos !== 12'd80) $display("FAIL cr_col5 got %0d want 80", cursor_pos); else n_pass++;
        n_chk++; if (wr_cnt - w0 !== 0) $display("FAIL no_write_cmds got %0d writes want 0", wr_cnt - w0); else n_pass++;
    endtask

    task automatic test_clear();
        int n, w0, s0, bad;
        w0 = wr_cnt; s0 = seq_bad; bad = 0;
        issue(2'd2, 7'd0, 8'h1F, 12'd0);
        n_chk++; if (wr_en !== 1'b1 || wr_addr !== 12'd0) $display("FAIL clear_first got en=%b addr=%0d want 1/0", wr_en, wr_addr); else n_pass++;
        wait_idle(n);
        n_chk++; if (n !== 2400) $display("FAIL clear_cycles got %0d want 2400", n); else n_pass++;
        n_chk++; if (wr_cnt - w0 !== 2400 || seq_bad !== s0) $display("FAIL clear_seq got %0d writes %0d gaps want 2400/0", wr_cnt - w0, seq_bad - s0); else n_pass++;
        n_chk++; if (last_addr !== 12'd2399) $display("FAIL clear_last got %0d want 2399", last_addr); else n_pass++;
        for (int i = 0; i < 2400; i++) if (ram_c[i] !== 7'd0 || ram_a[i] !== 8'h1F) bad++;
        n_chk++; if (bad !== 0) $display("FAIL clear_cells got %0d bad want 0", bad); else n_pass++;
        n_chk++; if (cursor_pos !== 12'd0) $display("FAIL clear_cursor got %0d want 0", cursor_pos); else n_pass++;
    endtask

    task automatic test_scroll();
        int n, w0;
        pre = 1'b1; @(negedge clk_in); pre = 1'b0;
        issue(2'd1, 7'd0, 8'd0, 12'd165); wait_idle(n);
        snap(); w0 = wr_cnt;
        issue(2'd3, 7'd0, 8'h03, 12'd0);
        n_chk++; if (rd_addr !== 12'd80 || wr_en !== 1'b0) $display("FAIL prime got rd=%0d en=%b want 80/0", rd_addr, wr_en); else n_pass++;
        @(negedge clk_in);
        n_chk++; if (wr_en !== 1'b1 || wr_addr !== 12'd0 || wr_char !== 7'h50) $display("FAIL copy0 got en=%b addr=%0d ch=%h want 1/0/50", wr_en, wr_addr, wr_char); else n_pass++;
        wait_idle(n);
        n_chk++; if (n + 1 !== 2401) $display("FAIL scroll_cycles got %0d want 2401", n + 1); else n_pass++;
        n_chk++; if (wr_cnt - w0 !== 2400) $display("FAIL scroll_writes got %0d want 2400", wr_cnt - w0); else n_pass++;
        n_chk++; if (scroll_bad(8'h03) !== 0) $display("FAIL scroll_cells got %0d bad want 0", scroll_bad(8'h03)); else n_pass++;
        n_chk++; if (cursor_pos !== 12'd85) $display("FAIL scroll_cursor got %0d want 85", cursor_pos); else n_pass++;
        issue(2'd1, 7'd0, 8'd0, 12'd5); wait_idle(n);
        issue(2'd3, 7'd0, 8'h60, 12'd0); wait_idle(n);
        n_chk++; if (cursor_pos !== 12'd5 || ram_a[2399] !== 8'h60) $display("FAIL scroll_row0 got cursor=%0d attr=%h want 5/60", cursor_pos, ram_a[2399]); else n_pass++;
    endtask

    task automatic test_wrap();
        int n;
        issue(2'd1, 7'd0, 8'd0, 12'd2399); wait_idle(n);
        snap(); snap_c[2399] = 7'h5A; snap_a[2399] = 8'h4E;
        issue(2'd0, 7'h5A, 8'h4E, 12'd0);
        n_chk++; if (wr_en !== 1'b1 || wr_addr !== 12'd2399) $display("FAIL wrap_write got en=%b addr=%0d want 1/2399", wr_en, wr_addr); else n_pass++;
        wait_idle(n);
        n_chk++; if (n !== 2402) $display("FAIL wrap_cycles got %0d want 2402", n); else n_pass++;
        n_chk++; if (cursor_pos !== 12'd2320) $display("FAIL wrap_cursor got %0d want 2320", cursor_pos); else n_pass++;
        n_chk++; if (ram_c[2319] !== 7'h5A || ram_a[2319] !== 8'h4E) $display("FAIL wrap_z got %h/%h want 5A/4E", ram_c[2319], ram_a[2319]); else n_pass++;
        n_chk++; if (scroll_bad(8'h00) !== 0) $display("FAIL wrap_cells got %0d bad want 0", scroll_bad(8'h00)); else n_pass++;
        issue(2'd1, 7'd0, 8'd0, 12'd2330); wait_idle(n);
        issue(2'd0, 7'h0A, 8'd0, 12'd0); wait_idle(n);
        n_chk++; if (n !== 2401 || cursor_pos !== 12'd2320) $display("FAIL lf_scroll got cycles=%0d cursor=%0d want 2401/2320", n, cursor_pos); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n, w0;
        logic [11:0] c0;
        w0 = wr_cnt; c0 = cursor_pos;
        cmd_op = 2'd0; cmd_char = 7'h61; cmd_attr = 8'h01; cmd_valid = 1'b1;
        @(negedge clk_in);
        n_chk++; if (cmd_ready !== 1'b0) $display("FAIL b2b_busy got ready=%b want 0", cmd_ready); else n_pass++;
        @(negedge clk_in);
        @(negedge clk_in);
        cmd_valid = 1'b0;
        wait_idle(n);
        n_chk++; if (wr_cnt - w0 !== 2) $display("FAIL b2b_writes got %0d want 2", wr_cnt - w0); else n_pass++;
        n_chk++; if (cursor_pos !== c0 + 12'd2) $display("FAIL b2b_cursor got %0d want %0d", cursor_pos, c0 + 12'd2); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] v;
        issue(2'd1, 7'd0, 8'd0, 12'd500); wait_idle(n);
        v = ram_a[2000];
        issue(2'd2, 7'd0, 8'h22, 12'd0);
        repeat (100) @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        n_chk++; if (wr_en !== 1'b0) $display("FAIL midrst_wr_en got %b want 0", wr_en); else n_pass++;
        n_chk++; if (cursor_pos !== 12'd0 || cmd_ready !== 1'b1) $display("FAIL midrst_state got cursor=%0d ready=%b want 0/1", cursor_pos, cmd_ready); else n_pass++;
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        n_chk++; if (ram_a[0] !== 8'h22 || ram_a[2000] !== v) $display("FAIL midrst_ram got %h/%h want 22/%h", ram_a[0], ram_a[2000], v); else n_pass++;
        issue(2'd0, 7'h31, 8'h07, 12'd0);
        n_chk++; if (wr_en !== 1'b1 || wr_addr !== 12'd0) $display("FAIL midrst_putc got en=%b addr=%0d want 1/0", wr_en, wr_addr); else n_pass++;
        wait_idle(n);
        n_chk++; if (cursor_pos !== 12'd1) $display("FAIL midrst_cursor got %0d want 1", cursor_pos); else n_pass++;
    endtask

    task automatic test_invariants();
        n_chk++; if (idle_wr !== 0) $display("FAIL idle_write got %0d want 0", idle_wr); else n_pass++;
        n_chk++; if (oob !== 0) $display("FAIL addr_range got %0d want 0", oob); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_putc();
        test_setpos();
        test_clear();
        test_scroll();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
